// File: rtl/vc_bus_mem_if.sv
// rtl/vc_bus_mem_if.sv - multiplexed 8-bit CPU external bus between tt_um_vc_cpu and vc_bus_mem
interface vc_bus_mem_if;
  logic [7:0] bus_out;
  logic       ind;
  logic       write;
  logic       latch_hi;
  logic       latch_lo;
  logic [7:0] bus_in;
  logic       ready;
  logic       irq;

  modport master (
    output bus_out, ind, write, latch_hi, latch_lo,
    input  bus_in, ready, irq
  );

  modport slave (
    input  bus_out, ind, write, latch_hi, latch_lo,
    output bus_in, ready, irq
  );
endinterface

// File: rtl/vc_bus_mem.sv
// rtl/vc_bus_mem.sv - byte memory target for the vc_cpu bus with wait states
// Optional periodic interrupt timer is built when VC_MEM_IRQ_EN is defined.
module vc_bus_mem #(
  parameter int ADDR_W       = 12,
  parameter int WAIT         = 0,
  parameter int TIMER_PERIOD = 1000,
  parameter int ACK_ADDR     = (1 << ADDR_W) - 1
) (
  input  logic         clk,
  input  logic         rst_n,
  vc_bus_mem_if.slave  bus
);

  localparam int         DEPTH     = 1 << ADDR_W;
  localparam bit         HAS_WAIT  = (WAIT != 0);
  localparam logic [3:0] WAIT_LOAD = HAS_WAIT ? 4'(WAIT - 1) : 4'd0;

  logic [7:0]        mem [DEPTH];
  logic [7:0]        addrhi;
  logic [6:0]        addrlo;
  logic              ind_q;
  logic              write_q;
  logic [3:0]        wcnt;
  logic [ADDR_W-1:0] ea;
  logic              trig;
  logic              ready;
  logic              commit;

  // Upper address bits beyond ADDR_W are dropped, so the space aliases.
  assign ea     = ADDR_W'({addrhi, addrlo, bus.ind});
  assign trig   = bus.latch_hi | bus.latch_lo | (bus.ind ^ ind_q) | (bus.write & ~write_q);
  assign ready  = (wcnt == 4'd0) & ~(trig & HAS_WAIT);
  assign commit = rst_n & bus.write & ready & ~bus.latch_hi & ~bus.latch_lo;

  assign bus.ready  = ready;
  assign bus.bus_in = mem[ea];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addrhi  <= 8'd0;
      addrlo  <= 7'd0;
      ind_q   <= 1'b0;
      write_q <= 1'b0;
      wcnt    <= 4'd0;
    end else begin
      ind_q   <= bus.ind;
      write_q <= bus.write;
      if (bus.latch_hi) addrhi <= bus.bus_out;
      if (bus.latch_lo) addrlo <= bus.bus_out[7:1];
      // A new trigger mid-wait restarts the window rather than queueing.
      if (trig && HAS_WAIT) wcnt <= WAIT_LOAD;
      else if (wcnt != 4'd0) wcnt <= wcnt - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (commit) mem[ea] <= bus.bus_out;
  end

`ifdef VC_MEM_IRQ_EN
  localparam logic [15:0]       TIMER_LAST = 16'(TIMER_PERIOD - 1);
  localparam logic [ADDR_W-1:0] ACK_EA     = ADDR_W'(ACK_ADDR);

  logic [15:0] timer;
  logic        irq;

  // Wrap has priority over the acknowledge write on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timer <= 16'd0;
      irq   <= 1'b0;
    end else if (timer == TIMER_LAST) begin
      timer <= 16'd0;
      irq   <= 1'b1;
    end else begin
      timer <= timer + 16'd1;
      if (commit && (ea == ACK_EA)) irq <= 1'b0;
    end
  end

  assign bus.irq = irq;
`else
  logic unused_irq_cfg;
  assign unused_irq_cfg = ^{16'(TIMER_PERIOD), ADDR_W'(ACK_ADDR)};
  assign bus.irq        = 1'b0;
`endif

endmodule
